// File: rtl/game_sequencer.sv
// ============================================================================
// Module      : game_sequencer
// Description : Round controller for the bomb-defuser board. It synchronises
//               the start button, clears the submodules, counts down, counts
//               strikes and latches the defused/exploded outcome.
//               Optional feature macro: STRIKE_PENALTY_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_sequencer #(
    parameter int TICK_DIV    = 1000000,
    parameter int ROUND_SEC   = 60,
    parameter int SHORT_SEC   = 30,
    parameter int PENALTY_SEC = 10,
    parameter int MAX_STRIKES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       timMod,
    input  logic       key_valid,
    input  logic       key_ok,
    output logic [2:0] state,
    output logic       sub_clr,
    output logic       run,
    output logic       tick,
    output logic [6:0] sec_left,
    output logic [1:0] strikes,
    output logic       win,
    output logic       boom
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_WIN  = 3'd3;
    localparam logic [2:0] S_BOOM = 3'd4;

    localparam int            c_pw       = $clog2(TICK_DIV);
    localparam logic [c_pw-1:0] c_pre_last = c_pw'(TICK_DIV - 1);
    localparam logic [7:0]    c_penalty  = 8'(PENALTY_SEC);
    localparam logic [1:0]    c_max_str  = 2'(MAX_STRIKES);

    logic            r_s1, r_s2, r_s3;
    logic            w_rise;
    logic [2:0]      r_state, w_next;
    logic [c_pw-1:0] r_pre;
    logic [6:0]      r_sec;
    logic [1:0]      r_strikes;
    logic            r_sub_clr, r_run, r_tick, r_win, r_boom;

    logic            w_tick_due, w_key_win, w_strike, w_strike_out, w_expire;
    logic [7:0]      w_dec;
    logic [6:0]      w_sec_new;
    logic [1:0]      w_strikes_nxt;
    logic            w_sub_clr, w_run, w_tick, w_win, w_boom;

    // Start button synchroniser; only the rising edge of the synced level is used
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= start;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_s3;

    assign w_tick_due = (r_state == S_RUN) && (r_pre == c_pre_last);
    assign w_key_win  = (r_state == S_RUN) && key_valid && key_ok;
`ifdef STRIKE_PENALTY_EN
    assign w_strike   = (r_state == S_RUN) && key_valid && !key_ok;
`else
    assign w_strike   = 1'b0;
`endif

    // Subtraction is done 8 bits wide and clamped so the count never wraps
    assign w_dec         = (w_tick_due ? 8'd1 : 8'd0) + (w_strike ? c_penalty : 8'd0);
    assign w_sec_new     = ({1'b0, r_sec} > w_dec) ? 7'({1'b0, r_sec} - w_dec) : 7'd0;
    assign w_strikes_nxt = r_strikes + (w_strike ? 2'd1 : 2'd0);
    assign w_strike_out  = w_strike && (w_strikes_nxt == c_max_str);
    assign w_expire      = (w_tick_due || w_strike) && (w_sec_new == 7'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_sub_clr <= 1'b1;
            r_run     <= 1'b0;
            r_tick    <= 1'b0;
            r_win     <= 1'b0;
            r_boom    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_sub_clr <= w_sub_clr;
            r_run     <= w_run;
            r_tick    <= w_tick;
            r_win     <= w_win;
            r_boom    <= w_boom;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_rise) w_next = S_ARM;
            S_ARM:   w_next = S_RUN;
            S_RUN: begin
                if (w_key_win)
                    w_next = S_WIN;
                else if (w_expire || w_strike_out)
                    w_next = S_BOOM;
            end
            S_WIN, S_BOOM: if (w_rise) w_next = S_ARM;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that they leave a flop
    always_comb begin
        w_sub_clr = 1'b0;
        w_run     = 1'b0;
        w_win     = 1'b0;
        w_boom    = 1'b0;
        w_tick    = w_tick_due && !w_key_win;
        case (w_next)
            S_IDLE, S_ARM: w_sub_clr = 1'b1;
            S_RUN:         w_run     = 1'b1;
            S_WIN:         w_win     = 1'b1;
            S_BOOM:        w_boom    = 1'b1;
            default:       w_sub_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre     <= '0;
            r_sec     <= 7'd0;
            r_strikes <= 2'd0;
        end else if (r_state == S_ARM) begin
            r_pre     <= '0;
            r_sec     <= timMod ? 7'(SHORT_SEC) : 7'(ROUND_SEC);
            r_strikes <= 2'd0;
        end else if (r_state == S_RUN) begin
            r_pre <= (r_pre == c_pre_last) ? '0 : r_pre + c_pw'(1);
            if (!w_key_win) begin
                r_strikes <= w_strikes_nxt;
                if (w_next == S_BOOM)
                    r_sec <= 7'd0;
                else if (w_tick_due || w_strike)
                    r_sec <= w_sec_new;
            end
        end
    end

    assign state    = r_state;
    assign sub_clr  = r_sub_clr;
    assign run      = r_run;
    assign tick     = r_tick;
    assign sec_left = r_sec;
    assign strikes  = r_strikes;
    assign win      = r_win;
    assign boom     = r_boom;

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
// ============================================================================
// Module      : tb_game_sequencer
// Description : Self-checking bench for game_sequencer against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_sequencer;

    localparam int TD = 4;
    localparam int RS = 5;
    localparam int SS = 3;
    localparam int PS = 2;
    localparam int MS = 3;
`ifdef STRIKE_PENALTY_EN
    localparam bit PEN_EN = 1'b1;
`else
    localparam bit PEN_EN = 1'b0;
`endif

    localparam logic [16:0] RESET_V = {3'd0, 1'b1, 1'b0, 1'b0, 7'd0, 2'd0, 1'b0, 1'b0};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       timMod = 1'b0;
    logic       key_valid = 1'b0;
    logic       key_ok = 1'b0;
    logic [2:0] state;
    logic       sub_clr, run, tick, win, boom;
    logic [6:0] sec_left;
    logic [1:0] strikes;
    logic [16:0] obs;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: phase 0..4, seconds left, strikes, cycles into the second
    int m_phase, m_secs, m_strikes, m_cnt;
    bit m_tick, m_s1, m_s2, m_s3;

    game_sequencer #(
        .TICK_DIV(TD), .ROUND_SEC(RS), .SHORT_SEC(SS),
        .PENALTY_SEC(PS), .MAX_STRIKES(MS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .timMod(timMod),
        .key_valid(key_valid), .key_ok(key_ok), .state(state),
        .sub_clr(sub_clr), .run(run), .tick(tick), .sec_left(sec_left),
        .strikes(strikes), .win(win), .boom(boom)
    );

    always #5 clk = ~clk;

    assign obs = {state, sub_clr, run, tick, sec_left, strikes, win, boom};

    function automatic logic [16:0] expv();
        return {3'(m_phase), (m_phase <= 1), (m_phase == 2), m_tick,
                7'(m_secs), 2'(m_strikes), (m_phase == 3), (m_phase == 4)};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_secs = 0; m_strikes = 0; m_cnt = 0;
        m_tick = 0; m_s1 = 0; m_s2 = 0; m_s3 = 0;
    endtask

    task automatic model_edge();
        bit rise, due, bad;
        int loss;
        if (!rst) begin
            model_reset();
            return;
        end
        rise = m_s2 && !m_s3;
        m_s3 = m_s2; m_s2 = m_s1; m_s1 = start;
        m_tick = 0;
        case (m_phase)
            1: begin
                m_secs = timMod ? SS : RS;
                m_strikes = 0; m_cnt = 0; m_phase = 2;
            end
            2: begin
                due = (m_cnt == TD - 1);
                m_cnt = (m_cnt + 1) % TD;
                if (key_valid && key_ok) begin
                    m_phase = 3;
                end else begin
                    bad = PEN_EN && key_valid && !key_ok;
                    loss = due ? 1 : 0;
                    if (bad) begin
                        loss += PS;
                        m_strikes++;
                    end
                    if (due || bad) m_secs = (m_secs > loss) ? m_secs - loss : 0;
                    m_tick = due;
                    if (m_secs == 0 || m_strikes >= MS) begin
                        m_phase = 4;
                        m_secs = 0;
                    end
                end
            end
            default: if (rise) m_phase = 1;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic start_round(input bit tm);
        int lat;
        timMod = tm;
        start = 1'b0;
        repeat (3) begin
            step();
            n_cmp++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL pre_start: got %b want %b", obs, expv());
            end
        end
        start = 1'b1;
        lat = 0;
        while (state != 3'd2 && lat < 10) begin
            step();
            lat++;
            n_cmp++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL start_seq: got %b want %b", obs, expv());
            end
        end
        n_cmp++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL start_latency: got %0d want 4", lat);
        end
    endtask

    task automatic finish_round();
        int n = 0;
        start = 1'b0;
        key_valid = 1'b0;
        while (state != 3'd3 && state != 3'd4 && n < 60) begin
            step();
            n++;
            n_cmp++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL finish: got %b want %b", obs, expv());
            end
        end
        n_cmp++;
        if (n >= 60) begin
            n_fail++;
            $display("FAIL finish_bound: got state %0d want 3 or 4", state);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) step();
        n_cmp++;
        if (obs !== RESET_V) begin
            n_fail++;
            $display("FAIL reset: got %b want %b", obs, RESET_V);
        end
        #3 rst = 1'b1;
    endtask

    task automatic test_start();
        start_round(1'b0);
        n_cmp++;
        if (sec_left !== 7'd5) begin
            n_fail++;
            $display("FAIL start_sec: got %0d want 5", sec_left);
        end
        repeat (6) begin
            step();
            n_cmp++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL start_hold: got %b want %b", obs, expv());
            end
        end
        n_cmp++;
        if (state !== 3'd2 || sec_left !== 7'd4) begin
            n_fail++;
            $display("FAIL single_round: got state %0d sec %0d want 2 4", state, sec_left);
        end
        finish_round();
    endtask

    task automatic test_timeout();
        int n = 0;
        int ticks = 0;
        start_round(1'b0);
        start = 1'b0;
        while (!boom && n < 40) begin
            step();
            n++;
            if (tick) ticks++;
            n_cmp++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL timeout_seq: got %b want %b", obs, expv());
            end
        end
        n_cmp++;
        if (n !== 20 || ticks !== 5 || state !== 3'd4 || sec_left !== 7'd0) begin
            n_fail++;
            $display("FAIL timeout: got cyc %0d ticks %0d state %0d sec %0d want 20 5 4 0",
                     n, ticks, state, sec_left);
        end
    endtask

    task automatic test_win();
        int ticks = 0;
        int n = 0;
        start_round(1'b1);
        start = 1'b0;
        while (ticks < 2 && n < 20) begin
            step();
            n++;
            if (tick) ticks++;
        end
        key_valid = 1'b1; key_ok = 1'b1;
        step();
        key_valid = 1'b0;
        n_cmp++;
        if (state !== 3'd3 || win !== 1'b1 || sec_left !== 7'd1) begin
            n_fail++;
            $display("FAIL win: got state %0d win %0d sec %0d want 3 1 1", state, win, sec_left);
        end
        repeat (8) begin
            step();
            n_cmp++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL win_hold: got %b want %b", obs, expv());
            end
        end
        start = 1'b1;
        n = 0;
        while (state != 3'd1 && n < 10) begin
            step();
            n++;
        end
        n_cmp++;
        if (state !== 3'd1 || win !== 1'b0 || sub_clr !== 1'b1) begin
            n_fail++;
            $display("FAIL rearm: got state %0d win %0d want 1 0", state, win);
        end
        finish_round();
    endtask

    task automatic test_strikes();
        start_round(1'b0);
        start = 1'b0;
        key_valid = 1'b1; key_ok = 1'b0;
        step();
        step();
        key_valid = 1'b0;
        n_cmp++;
        if (sec_left !== (PEN_EN ? 7'd1 : 7'd5) || strikes !== (PEN_EN ? 2'd2 : 2'd0)) begin
            n_fail++;
            $display("FAIL two_strikes: got sec %0d str %0d", sec_left, strikes);
        end
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        n_cmp++;
        if (state !== (PEN_EN ? 3'd4 : 3'd2) || strikes !== (PEN_EN ? 2'd3 : 2'd0)
            || obs !== expv()) begin
            n_fail++;
            $display("FAIL third_strike: got %b want %b", obs, expv());
        end
        finish_round();
    endtask

    task automatic test_strike_tick();
        start_round(1'b1);
        start = 1'b0;
        repeat (3) step();
        key_valid = 1'b1; key_ok = 1'b0;
        step();
        key_valid = 1'b0;
        n_cmp++;
        if (state !== (PEN_EN ? 3'd4 : 3'd2) || sec_left !== (PEN_EN ? 7'd0 : 7'd2)) begin
            n_fail++;
            $display("FAIL strike_tick: got state %0d sec %0d", state, sec_left);
        end
        finish_round();
    endtask

    task automatic test_win_final_tick();
        start_round(1'b1);
        start = 1'b0;
        repeat (11) step();
        key_valid = 1'b1; key_ok = 1'b1;
        step();
        key_valid = 1'b0;
        n_cmp++;
        if (state !== 3'd3 || sec_left !== 7'd1 || win !== 1'b1) begin
            n_fail++;
            $display("FAIL win_final_tick: got state %0d sec %0d want 3 1", state, sec_left);
        end
    endtask

    task automatic test_ignored_keys();
        logic [16:0] held;
        held = obs;
        for (int i = 0; i < 6; i++) begin
            key_valid = 1'b1; key_ok = i[0];
            step();
            n_cmp++;
            if (obs !== held) begin
                n_fail++;
                $display("FAIL keys_done: got %b want %b", obs, held);
            end
        end
        key_valid = 1'b0;
        #2 rst = 1'b0;
        #1 rst = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            key_valid = 1'b1; key_ok = i[0];
            step();
            n_cmp++;
            if (obs !== RESET_V) begin
                n_fail++;
                $display("FAIL keys_idle: got %b want %b", obs, RESET_V);
            end
        end
        key_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        int arms = 0;
        start_round(1'b0);
        repeat (5) step();
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (obs !== RESET_V) begin
            n_fail++;
            $display("FAIL async_reset: got %b want %b", obs, RESET_V);
        end
        model_reset();
        rst = 1'b1;
        repeat (15) begin
            step();
            if (state == 3'd1) arms++;
            n_cmp++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL post_reset: got %b want %b", obs, expv());
            end
        end
        n_cmp++;
        if (arms !== 1) begin
            n_fail++;
            $display("FAIL one_rise: got %0d arms want 1", arms);
        end
        finish_round();
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            start     = ($urandom_range(0, 15) == 0);
            timMod    = 1'($urandom);
            key_valid = ($urandom_range(0, 6) == 0);
            key_ok    = 1'($urandom);
            step();
            n_cmp++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b want %b", i, obs, expv());
            end
        end
        start = 1'b0;
        key_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_timeout();
        test_win();
        test_strikes();
        test_strike_tick();
        test_win_final_tick();
        test_ignored_keys();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
